// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and state encodings shared by the sequential multiplier/divider
package muldiv_pkg;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction
endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/result bundle between a requester and muldiv_seq
interface muldiv_seq_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (output start, op, a, b, input hi, lo, busy, done, div_zero);
    modport slave (input start, op, a, b, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/muldiv_addsub.sv
// muldiv_addsub: N-bit adder/subtractor; cin_i=1 subtracts and cout_o=1 then means no borrow
module muldiv_addsub #(
    parameter int N = 33
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i ^ {N{cin_i}}} + {{N{1'b0}}, cin_i};
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: one-bit-per-cycle signed/unsigned multiply and restoring divide on magnitudes,
// with sign correction applied in a final FIX cycle.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic         clock,
    input logic         reset,
    muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0]   ma_q, ma_d, mb_q, mb_d, acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d, dz_q, dz_d;
    logic               is_div, in_sa, in_sb, b_zero, as_co;
    logic [WIDTH:0]     as_a, as_y, part;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign is_div = is_div_op(op_q);
    assign in_sa  = is_signed_op(bus.op) & bus.a[WIDTH-1];
    assign in_sb  = is_signed_op(bus.op) & bus.b[WIDTH-1];
    assign b_zero = mb_q == '0;

    // ma_q holds the multiplier (shifting right) or dividend/quotient (shifting left); acc_q is product high / remainder
    assign as_a = is_div ? {acc_q, ma_q[WIDTH-1]} : {1'b0, acc_q};

    muldiv_addsub #(.N(WIDTH + 1)) u_addsub (
        .a_i   (as_a),
        .b_i   ({1'b0, mb_q}),
        .cin_i (is_div),
        .sum_o (as_y),
        .cout_o(as_co)
    );

    assign part     = ma_q[0] ? as_y : {1'b0, acc_q};
    assign prod     = {acc_q, ma_q};
    assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = RUN;
                op_d    = bus.op;
                sa_d    = in_sa;
                sb_d    = in_sb;
                ma_d    = in_sa ? -bus.a : bus.a;
                mb_d    = in_sb ? -bus.b : bus.b;
                acc_d   = '0;
                cnt_d   = '0;
                dz_d    = 1'b0;
            end
            RUN: begin
                cnt_d   = cnt_q + CW'(1);
                acc_d   = is_div ? (as_co ? as_y[WIDTH-1:0] : as_a[WIDTH-1:0]) : part[WIDTH:1];
                ma_d    = is_div ? {ma_q[WIDTH-2:0], as_co} : {part[0], ma_q[WIDTH-1:1]};
                state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : RUN;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                hi_d    = is_div ? (sa_q ? -acc_q : acc_q) : prod_fix[2*WIDTH-1:WIDTH];
                lo_d    = is_div ? (b_zero ? '1 : ((sa_q ^ sb_q) ? -ma_q : ma_q)) : prod_fix[WIDTH-1:0];
                dz_d    = is_div & b_zero;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ma_q    <= '0;
            mb_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = state_q != IDLE;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; legal range 4..64.
REQ-002 Port: clock  in  1  rising-edge system clock.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  request pulse; sampled only in IDLE.
REQ-005 Port: op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 Port: a  in  WIDTH  multiplicand / dividend.
REQ-007 Port: b  in  WIDTH  multiplier / divisor.
REQ-008 Port: hi  out  WIDTH  product upper half / remainder.
REQ-009 Port: lo  out  WIDTH  product lower half / quotient.
REQ-010 Port: busy  out  1  high from the cycle after start acceptance until the result is written.
REQ-011 Port: done  out  1  single-cycle pulse; hi/lo/div_zero are valid and new in this cycle.
REQ-012 Port: div_zero  out  1  set with done when a DIV/DIVU had b==0; cleared on the next accepted start.

Function
REQ-013 States: IDLE, RUN, FIX; IDLE->RUN on start; RUN->FIX after WIDTH iterations; FIX->IDLE unconditionally.
REQ-014 Acceptance edge: latch op, sign flags, and magnitudes |a| and |b| (signed ops) or raw a and b (unsigned ops); clear accumulator; set counter to 0.
REQ-015 RUN: one iteration per cycle, counter width clog2(WIDTH)+1; leave RUN when counter==WIDTH-1.
REQ-016 Multiply iteration: unsigned shift-add on magnitudes; WIDTH+1-bit add keeps the carry; 2*WIDTH-bit result.
REQ-017 Divide iteration: restoring shift-subtract on magnitudes; WIDTH+1-bit subtract; quotient bit = NOT borrow.
REQ-018 FIX, MULT: negate the 2*WIDTH-bit product when the operand signs differ.
REQ-019 FIX, DIV: negate the quotient when the signs differ; the remainder takes the sign of the dividend (truncation toward zero).
REQ-020 hi, lo, and div_zero are updated on the FIX->IDLE edge; done is high for exactly the following cycle.
REQ-021 Latency: start sampled at edge k -> busy high for cycles k+1..k+WIDTH+1 -> done high for cycle k+WIDTH+2; latency is independent of data.
REQ-022 start while busy is ignored; the in-flight operation is not disturbed.
REQ-023 start in the done cycle is accepted (busy is low then), giving back-to-back operations.
REQ-024 hi and lo hold their last result until the next FIX write; inputs a, b, and op are don't-care after acceptance.
REQ-025 Divide by zero: normal latency; hi = a, lo = all ones, div_zero = 1.
REQ-026 Signed overflow (DIV of the most-negative value by -1): lo = most-negative value, hi = 0, div_zero = 0.
REQ-027 op values are fully decoded; no illegal op exists.

Reset
REQ-028 reset high at a clock edge forces IDLE with busy=0, done=0, div_zero=0, hi=0, lo=0, and counter=0.
REQ-029 reset mid-operation aborts the operation with no done pulse; reset overrides a simultaneous start.

Structure
REQ-030 Package muldiv_pkg holds the op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the state encoding (IDLE, RUN, FIX).
REQ-031 One sub-module, muldiv_addsub: parametrised WIDTH+1-bit adder/subtractor with carry-in, shared by multiply (add) and divide (subtract); used once.
REQ-032 hi, lo, busy, done, and div_zero are registered outputs; there is no combinational path from the inputs to the outputs.

Verification (WIDTH=32)
REQ-033 MULT a=0xFFFFFFFD, b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done exactly 34 edges after start; busy high for 33 cycles.
REQ-034 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MULT a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-035 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=0xFFFFFFFF, b=0x10 -> lo=0x0FFFFFFF, hi=0x0000000F.
REQ-036 DIV a=0x12345678, b=0 -> div_zero=1, hi=0x12345678, lo=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-037 Handshake: a second start during busy is ignored (result matches the first op); a start in the done cycle is accepted and its done follows 34 edges later.
REQ-038 Reset asserted 10 cycles into RUN -> next cycle busy=0, hi=lo=0, and no done; a fresh MULT 6*7 then yields lo=0x0000002A, hi=0.
